// File: rtl/imul_issue_sched.sv
// imul_issue_sched: round-robin issue scheduler for the shared multiply/secondary unit
// Ports: clk/rst (sync, active high), clkEn freezes all state, flush kills in-flight ops.
//        req{0,1}_*: valid/ready issue ports (op, long flag, R/C operands, tag).
//        mul_*: issue strobe and operands to the unit; mul_res: unit result.
//        res_*: result strobe with originating port, tag and data.
module imul_issue_sched #(
    parameter int LAT      = 3,
    parameter int LONG_LAT = 8,
    parameter int TAGW     = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clkEn,
    input  logic            flush,
    input  logic            req0_valid,
    input  logic [12:0]     req0_op,
    input  logic            req0_long,
    input  logic [64:0]     req0_R,
    input  logic [64:0]     req0_C,
    input  logic [TAGW-1:0] req0_tag,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [12:0]     req1_op,
    input  logic            req1_long,
    input  logic [64:0]     req1_R,
    input  logic [64:0]     req1_C,
    input  logic [TAGW-1:0] req1_tag,
    output logic            req1_ready,
    output logic            mul_en,
    output logic [12:0]     mul_op_prev,
    output logic [64:0]     mul_R,
    output logic [64:0]     mul_C,
    input  logic [64:0]     mul_res,
    output logic            res_valid,
    output logic            res_port,
    output logic [TAGW-1:0] res_tag,
    output logic [64:0]     res_data
);
    localparam int E   = TAGW + 2;
    localparam int CW  = $clog2(LAT + 1);
    localparam int LBW = $clog2(LONG_LAT);

    logic [LONG_LAT-1:0][E-1:0] sr_q, sr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [LBW-1:0]             lb_q, lb_d;
    logic                       rr_q, rr_d;
    logic                       retire, blk, long_ok, g0, g1, win, wlong;
    logic [TAGW-1:0]            wtag;

    always_comb begin
        retire      = sr_q[0][E-1] & clkEn & ~flush & ~rst;
        blk         = ~clkEn | flush | rst | (lb_q != '0);
        // a long op needs an empty pipe; a head retiring this cycle already counts as gone
        long_ok     = cnt_q == CW'(retire);
        g0          = req0_valid & ~blk & (~req0_long | long_ok);
        g1          = req1_valid & ~blk & (~req1_long | long_ok);
        win         = (g0 & g1) ? rr_q : g1;
        wlong       = win ? req1_long : req0_long;
        wtag        = win ? req1_tag : req0_tag;
        req0_ready  = g0 & ~win;
        req1_ready  = g1 & win;
        mul_en      = g0 | g1;
        mul_op_prev = ~mul_en ? '0 : win ? req1_op : req0_op;
        mul_R       = ~mul_en ? '0 : win ? req1_R : req0_R;
        mul_C       = ~mul_en ? '0 : win ? req1_C : req0_C;
        res_valid   = retire;
        res_port    = retire & sr_q[0][E-2];
        res_tag     = retire ? sr_q[0][TAGW-1:0] : '0;
        res_data    = retire ? mul_res : '0;
        sr_d        = clkEn ? {E'(0), sr_q[LONG_LAT-1:1]} : sr_q;
        if (mul_en && wlong) sr_d[LONG_LAT-1] = {1'b1, win, wtag};
        if (mul_en && !wlong) sr_d[LAT-1] = {1'b1, win, wtag};
        if (flush) sr_d = '0;
        cnt_d       = flush ? '0 : cnt_q + CW'(mul_en) - CW'(retire);
        lb_d        = flush ? '0 : (mul_en & wlong) ? LBW'(LONG_LAT - 1) :
                      (clkEn && lb_q != '0) ? lb_q - 1'b1 : lb_q;
        rr_d        = mul_en ? ~win : rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            lb_q  <= '0;
            rr_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            lb_q  <= lb_d;
            rr_q  <= rr_d;
        end
    end
endmodule
